// File: rtl/key_duty_ctrl.sv
// Button-driven duty setpoint: syncs and debounces up/down keys, applies
// stepped, saturating changes with auto-repeat while a key is held.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no key accepted, waiting for a valid command
// PRESS   | key seen, debouncing; step on DEB_TICKS-th tick
// HOLD    | first step done, waiting REPEAT_DELAY ticks before auto-repeat
// REPEAT  | auto-repeat, one step every REPEAT_RATE ticks
// RELEASE | key let go, waiting DEB_TICKS quiet ticks before re-arming
module key_duty_ctrl #(
   parameter int DUTY_W       = 10,
   parameter int DUTY_INIT    = 1016,
   parameter int STEP         = 8,
   parameter int TICK_DIV     = 50000,
   parameter int DEB_TICKS    = 20,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        key,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_upd
);

   localparam int TC_MAX0 = (DEB_TICKS > REPEAT_DELAY) ? DEB_TICKS : REPEAT_DELAY;
   localparam int TC_MAX  = (TC_MAX0 > REPEAT_RATE) ? TC_MAX0 : REPEAT_RATE;
   localparam int TC_W    = $clog2(TC_MAX + 1);
   localparam int PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] CMD_UP   = 2'b01;
   localparam logic [1:0] CMD_DN   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_PRESS, S_HOLD, S_REPEAT, S_RELEASE
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        sync1, sync2;
   logic [1:0]        cmd;
   logic [1:0]        dir;
   logic [PS_W-1:0]   ps_cnt;
   logic              tick;
   logic [TC_W-1:0]   tcnt;
   logic              deb_tc, dly_tc, rate_tc;
   logic              do_step;
   logic              tcnt_clr;
   logic [DUTY_W:0]   step_ext, sum, diff;
   logic [DUTY_W-1:0] duty_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
      end
   end

   // both keys together decode as no key
   always_comb begin
      cmd = CMD_NONE;
      if (sync2 == CMD_UP || sync2 == CMD_DN)
         cmd = sync2;
   end

   always_ff @(posedge clk) begin
      if (rst)
         ps_cnt <= '0;
      else if (tick)
         ps_cnt <= '0;
      else
         ps_cnt <= ps_cnt + 1'b1;
   end

   assign tick    = (ps_cnt == PS_W'(TICK_DIV - 1));
   assign deb_tc  = tick && (tcnt == TC_W'(DEB_TICKS - 1));
   assign dly_tc  = tick && (tcnt == TC_W'(REPEAT_DELAY - 1));
   assign rate_tc = tick && (tcnt == TC_W'(REPEAT_RATE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         dir   <= CMD_NONE;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && cmd != CMD_NONE)
            dir <= cmd;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (cmd != CMD_NONE) state_nxt = S_PRESS;
         S_PRESS:   if (cmd != dir) state_nxt = S_IDLE;
                    else if (deb_tc) state_nxt = S_HOLD;
         S_HOLD:    if (cmd != dir) state_nxt = S_RELEASE;
                    else if (dly_tc) state_nxt = S_REPEAT;
         S_REPEAT:  if (cmd != dir) state_nxt = S_RELEASE;
         S_RELEASE: if (cmd == CMD_NONE && deb_tc) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      do_step  = 1'b0;
      tcnt_clr = (state_nxt != state);
      case (state)
         S_PRESS:   do_step = (cmd == dir) && deb_tc;
         S_HOLD:    do_step = (cmd == dir) && dly_tc;
         S_REPEAT:  if (cmd == dir && rate_tc) begin
                       do_step  = 1'b1;
                       tcnt_clr = 1'b1;
                    end
         S_RELEASE: if (cmd != CMD_NONE) tcnt_clr = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         tcnt <= '0;
      else if (tcnt_clr)
         tcnt <= '0;
      else if (tick && state != S_IDLE)
         tcnt <= tcnt + 1'b1;
   end

   // one guard bit catches overflow/underflow before clamping to the rails
   always_comb begin
      step_ext = (DUTY_W + 1)'(STEP);
      sum      = {1'b0, duty} + step_ext;
      diff     = {1'b0, duty} - step_ext;
      if (dir == CMD_UP)
         duty_step = sum[DUTY_W] ? {DUTY_W{1'b1}} : sum[DUTY_W-1:0];
      else
         duty_step = diff[DUTY_W] ? '0 : diff[DUTY_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty     <= DUTY_W'(DUTY_INIT);
         duty_upd <= 1'b0;
      end else begin
         duty_upd <= 1'b0;
         if (do_step) begin
            duty     <= duty_step;
            duty_upd <= (duty_step != duty);
         end
      end
   end

endmodule

// File: tb/tb_key_duty_ctrl.sv
// Directed bench for key_duty_ctrl: table of key/reset phases with expected
// duty and pulse counts, plus a second instance for the lower rail.
module tb_key_duty_ctrl;

   localparam int DUTY_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        key = 2'b01;
   logic [1:0]        key2 = 2'b00;
   logic [DUTY_W-1:0] duty, duty2;
   logic              duty_upd, duty_upd2;

   always #5 clk = ~clk;

   key_duty_ctrl #(
      .DUTY_W(10), .DUTY_INIT(1016), .STEP(8), .TICK_DIV(4),
      .DEB_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
   ) dut (
      .clk(clk), .rst(rst), .key(key), .duty(duty), .duty_upd(duty_upd)
   );

   key_duty_ctrl #(
      .DUTY_W(10), .DUTY_INIT(4), .STEP(8), .TICK_DIV(4),
      .DEB_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
   ) dut_lo (
      .clk(clk), .rst(rst), .key(key2), .duty(duty2), .duty_upd(duty_upd2)
   );

   typedef struct {
      logic       rst;
      logic [1:0] key;
      int         cyc;
      int         exp_duty;
      int         exp_upd;
      string      name;
   } vec_t;

   vec_t              vt[$];
   int                n_chk  = 0;
   int                n_fail = 0;
   bit                mon_en = 1'b0;
   bit                rst_at_edge = 1'b1;
   logic [DUTY_W-1:0] prev_duty = '0;

   task automatic add(input logic r, input logic [1:0] k, input int c,
                      input int d, input int u, input string nm);
      vec_t v;
      v.rst = r; v.key = k; v.cyc = c; v.exp_duty = d; v.exp_upd = u; v.name = nm;
      vt.push_back(v);
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) rst_at_edge = rst;

   // duty_upd must flag exactly the cycles where duty took a new value
   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst_at_edge) begin
            n_chk++;
            if (duty_upd !== (duty != prev_duty)) begin
               n_fail++;
               $display("FAIL upd_vs_change at %0t: duty_upd=%b, duty %0d -> %0d",
                        $time, duty_upd, prev_duty, duty);
            end
         end
         prev_duty = duty;
      end
   end

   initial begin
      int pulses;

      add(1, 2'b01,  2, 1016, 0, "reset");
      add(0, 2'b00,  4, 1016, 0, "post_reset");
      add(0, 2'b10,  8, 1016, 0, "glitch");
      add(0, 2'b00, 24, 1016, 0, "glitch_rel");
      add(0, 2'b10, 16, 1008, 1, "single");
      for (int i = 0; i < 3; i++) begin
         add(0, 2'b00, 2, 1008, 0, "bounce_lo");
         add(0, 2'b10, 2, 1008, 0, "bounce_hi");
      end
      add(0, 2'b00, 24, 1008, 0, "bounce_rel");
      add(1, 2'b00,  2, 1016, 0, "reset2");
      add(0, 2'b10, 60,  976, 5, "repeat");
      add(0, 2'b00, 24,  976, 0, "repeat_rel");
      add(1, 2'b00,  2, 1016, 0, "reset3");
      add(0, 2'b01, 16, 1023, 1, "sat_up");
      add(0, 2'b00, 24, 1023, 0, "sat_up_rel");
      add(0, 2'b01, 16, 1023, 0, "sat_up_rail");
      add(0, 2'b00, 24, 1023, 0, "sat_rail_rel");
      add(0, 2'b11, 40, 1023, 0, "both_keys");
      add(0, 2'b00,  8, 1023, 0, "both_rel");
      add(1, 2'b00,  2, 1016, 0, "reset4");
      add(0, 2'b10, 36, 1000, 2, "rpt_pre_rst");
      add(1, 2'b10,  1, 1016, 0, "rst_mid_hold");
      add(1, 2'b00,  1, 1016, 0, "rst_mid_hold2");
      add(0, 2'b00, 24, 1016, 0, "post_rst_idle");
      add(0, 2'b10, 24, 1008, 1, "dir_first");
      add(0, 2'b01, 16, 1008, 0, "dir_switch");
      add(0, 2'b00,  6, 1008, 0, "short_gap");
      add(0, 2'b01, 16, 1008, 0, "no_repress");
      add(0, 2'b00, 24, 1008, 0, "full_gap");
      add(0, 2'b01, 16, 1016, 1, "repress_up");
      add(0, 2'b00, 24, 1016, 0, "repress_rel");

      foreach (vt[i]) begin
         rst = vt[i].rst;
         key = vt[i].key;
         pulses = 0;
         repeat (vt[i].cyc) begin
            @(posedge clk);
            #1;
            if (duty_upd) pulses++;
         end
         check({vt[i].name, "_duty"}, int'(duty), vt[i].exp_duty);
         check({vt[i].name, "_pulses"}, pulses, vt[i].exp_upd);
         if (i == 0) begin
            prev_duty = duty;
            mon_en = 1'b1;
         end
      end

      // lower rail on the DUTY_INIT=4 instance
      check("lo_init", int'(duty2), 4);
      key2 = 2'b10;
      pulses = 0;
      repeat (16) begin
         @(posedge clk); #1;
         if (duty_upd2) pulses++;
      end
      check("lo_down_duty", int'(duty2), 0);
      check("lo_down_pulses", pulses, 1);
      key2 = 2'b00;
      repeat (24) @(posedge clk);
      #1;
      key2 = 2'b10;
      pulses = 0;
      repeat (16) begin
         @(posedge clk); #1;
         if (duty_upd2) pulses++;
      end
      check("lo_rail_duty", int'(duty2), 0);
      check("lo_rail_pulses", pulses, 0);
      key2 = 2'b00;
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
